// File: rtl/and_16.sv
// 16-bit all-ones detector: balanced 2-input AND tree, registered once.
// One clock of latency from a to out; out clears asynchronously on rst.
module and_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  output logic        out
);

  logic [7:0] w_lvl1;
  logic [3:0] w_lvl2;
  logic [1:0] w_lvl3;
  logic       w_lvl4;
  logic       r_out;

  // Level 1 pairs adjacent bits; each later level pairs adjacent results.
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_lvl1
      assign w_lvl1[g] = a[2*g] & a[2*g+1];
    end
    for (g = 0; g < 4; g++) begin : g_lvl2
      assign w_lvl2[g] = w_lvl1[2*g] & w_lvl1[2*g+1];
    end
    for (g = 0; g < 2; g++) begin : g_lvl3
      assign w_lvl3[g] = w_lvl2[2*g] & w_lvl2[2*g+1];
    end
  endgenerate

  assign w_lvl4 = w_lvl3[0] & w_lvl3[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= 1'b0;
    else     r_out <= w_lvl4;
  end

  assign out = r_out;

endmodule

// File: tb/tb_and_16.sv
// Self-checking bench for and_16 against an "a == 16'hFFFF, one cycle later" model.
module tb_and_16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic        out;

  int checks;
  int failures;

  and_16 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply a value at the falling edge, then return 1 time unit after the next rising edge.
  task automatic drive_cycle(input logic [15:0] val);
    @(negedge clk);
    a = val;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b1;
    a   = 16'hFFFF;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: out=%b expected=0", out);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 1'b0) begin
        failures++;
        $display("FAIL reset_held cycle %0d: out=%b expected=0", i, out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_before_edge: out=%b expected=0", out);
    end
    @(posedge clk);
    #1;
    exp = (a == 16'hFFFF);
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL reset_release_first_edge: out=%b expected=%b", out, exp);
    end
  endtask

  task automatic test_basic();
    logic [15:0] vals [9];
    logic        exp;
    vals = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF,
             16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
    foreach (vals[i]) begin
      drive_cycle(vals[i]);
      exp = (vals[i] == 16'hFFFF);
      checks++;
      if (out !== exp) begin
        failures++;
        $display("FAIL basic a=%h: out=%b expected=%b", vals[i], out, exp);
      end
    end
  endtask

  task automatic test_walking_zero();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 16'hFFFF;
      v[i] = 1'b0;
      drive_cycle(v);
      checks++;
      if (out !== 1'b0) begin
        failures++;
        $display("FAIL walking_zero bit %0d a=%h: out=%b expected=0", i, v, out);
      end
      drive_cycle(16'hFFFF);
      checks++;
      if (out !== 1'b1) begin
        failures++;
        $display("FAIL walking_zero_ones after bit %0d: out=%b expected=1", i, out);
      end
    end
  endtask

  task automatic test_latency();
    drive_cycle(16'h0000);
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL latency_setup: out=%b expected=0", out);
    end
    #2;
    a = 16'hFFFF;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL latency_mid_cycle: out=%b expected=0", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL latency_next_edge: out=%b expected=1", out);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(16'hFFFF);
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL async_setup: out=%b expected=1", out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL async_assert_between_edges: out=%b expected=0", out);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin
      failures++;
      $display("FAIL async_release_before_edge: out=%b expected=0", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL async_recover_first_edge: out=%b expected=1", out);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic        exp;
    int          bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 10 == 9) v = 16'hFFFF;
      else             v = 16'($urandom);
      drive_cycle(v);
      exp = (v == 16'hFFFF);
      checks++;
      if (out !== exp) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random step %0d a=%h: out=%b expected=%b", i, v, out, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a        = 16'h0000;
    test_reset();
    test_basic();
    test_walking_zero();
    test_latency();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
